// File: rtl/dspl_drv_nexys_a7.sv
// Time-multiplexed driver for the Nexys A7 8-digit common-anode 7-segment display.
// Optional anti-ghosting anode blanking at each digit switch: define DSPL_DIGIT_BLANK_GUARD_EN.
module dspl_drv_nexys_a7 #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_ddp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYCLES);
`ifdef DSPL_DIGIT_BLANK_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_an;
  logic [7:0]    r_dec;

  logic          w_wrap;
  logic          w_blank;
  logic [5:0]    w_sel;
  logic [6:0]    w_seg;
  logic [7:0]    w_an_sel;
  logic [7:0]    w_an_next;
  logic [7:0]    w_dec_next;

  assign w_wrap  = (r_cnt == CNT_MAX);
  assign w_blank = GUARD_EN && (r_cnt < GUARD_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_sel = d1;
    case (r_idx)
      3'd0: w_sel = d1;
      3'd1: w_sel = d2;
      3'd2: w_sel = d3;
      3'd3: w_sel = d4;
      3'd4: w_sel = d5;
      3'd5: w_sel = d6;
      3'd6: w_sel = d7;
      3'd7: w_sel = d8;
      default: w_sel = d1;
    endcase
  end

  // Active-low abcdefg pattern of the selected digit's hex value.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_sel[4:1])
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Only the anode whose position equals the index can go low, so at most one is ever on.
  for (genvar gi = 0; gi < 8; gi++) begin : g_an
    assign w_an_sel[gi] = ~(r_idx == 3'(gi));
  end

  assign w_an_next  = (w_sel[5] && !w_blank) ? w_an_sel : 8'hFF;
  assign w_dec_next = w_sel[5] ? {w_seg, w_sel[0]} : 8'hFF;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_dec <= 8'hFF;
    end else begin
      r_an  <= w_an_next;
      r_dec <= w_dec_next;
    end
  end

  assign an      = r_an;
  assign dec_ddp = r_dec;

endmodule

// File: tb/tb_dspl_drv_nexys_a7.sv
// Directed self-checking bench for dspl_drv_nexys_a7 (REFRESH_DIV = 4, or 32 with guard of 4
// when DSPL_DIGIT_BLANK_GUARD_EN is defined).
module tb_dspl_drv_nexys_a7;

`ifdef DSPL_DIGIT_BLANK_GUARD_EN
  localparam int RD = 32;
  localparam int GC = 4;
`else
  localparam int RD = 4;
  localparam int GC = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0] an;
  logic [7:0] dec_ddp;

  int checks = 0;
  int passed = 0;

  dspl_drv_nexys_a7 #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
    .clock(clock), .reset(reset),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .an(an), .dec_ddp(dec_ddp)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [5:0] scan_d(input int k);
    return {1'b1, 4'(k), 1'b1};
  endfunction

  function automatic logic [7:0] an_of(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  task automatic set_scan();
    d1 = scan_d(0); d2 = scan_d(1); d3 = scan_d(2); d4 = scan_d(3);
    d5 = scan_d(4); d6 = scan_d(5); d7 = scan_d(6); d8 = scan_d(7);
  endtask

  // Leaves the bench at a falling edge with reset low; the next rising edge is the first scan cycle.
  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_scan();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (an !== 8'hFF || dec_ddp !== 8'hFF)
      $display("FAIL reset_state an=%h dec=%h want FF/FF", an, dec_ddp);
    else passed++;
    reset = 1'b0;
    for (int k = 1; k <= RD + 1; k++) begin
      @(negedge clock);
      checks++;
      if (an !== ((k <= RD) ? 8'hFE : 8'hFD))
        $display("FAIL reset_release_slot cyc=%0d an=%h want %h", k, an, (k <= RD) ? 8'hFE : 8'hFD);
      else passed++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 8'hFF || dec_ddp !== 8'hFF)
      $display("FAIL reset_async an=%h dec=%h want FF/FF", an, dec_ddp);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= RD + 1; k++) begin
      @(negedge clock);
      checks++;
      if (an !== ((k <= RD) ? 8'hFE : 8'hFD))
        $display("FAIL reset_restart cyc=%0d an=%h want %h", k, an, (k <= RD) ? 8'hFE : 8'hFD);
      else passed++;
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] exp_dec;
    set_scan();
    release_reset();
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < RD; c++) begin
        @(negedge clock);
        exp_dec = {seg_of(4'(s % 8)), 1'b1};
        checks++;
        if (an !== an_of(s % 8) || dec_ddp !== exp_dec)
          $display("FAIL scan_order slot=%0d cyc=%0d an=%h dec=%h want %h/%h",
                   s, c, an, dec_ddp, an_of(s % 8), exp_dec);
        else passed++;
        checks++;
        if ($countones(~an) > 1)
          $display("FAIL scan_onehot slot=%0d an=%h want at most one low", s, an);
        else passed++;
      end
    end
  endtask

  task automatic test_decode();
    logic       dp;
    logic [7:0] exp_dec;
    set_scan();
    for (int v = 0; v < 16; v++) begin
      dp = 4'(v) == 4'h8 ? 1'b0 : ((v % 3) != 2);
      d1 = {1'b1, 4'(v), dp};
      release_reset();
      @(negedge clock);
      exp_dec = {seg_of(4'(v)), dp};
      checks++;
      if (an !== 8'hFE || dec_ddp !== exp_dec)
        $display("FAIL decode v=%h an=%h dec=%b want FE/%b", v, an, dec_ddp, exp_dec);
      else passed++;
    end
    // Literal vectors, independent of the table function.
    d1 = 6'b1_0000_1; @(negedge clock); @(negedge clock);
    checks++;
    if (dec_ddp !== 8'b00000011) $display("FAIL decode_0 dec=%b want 00000011", dec_ddp);
    else passed++;
    d1 = 6'b1_0001_1; @(negedge clock);
    checks++;
    if (dec_ddp !== 8'b10011111) $display("FAIL decode_1 dec=%b want 10011111", dec_ddp);
    else passed++;
  endtask

  task automatic test_disable();
    logic [7:0] exp_an, exp_dec;
    set_scan();
    d3 = 6'b0_0101_1;
    release_reset();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < RD; c++) begin
        @(negedge clock);
        exp_an  = (s == 2) ? 8'hFF : an_of(s);
        exp_dec = (s == 2) ? 8'hFF : {seg_of(4'(s)), 1'b1};
        checks++;
        if (an !== exp_an || dec_ddp !== exp_dec)
          $display("FAIL disable slot=%0d cyc=%0d an=%h dec=%h want %h/%h",
                   s, c, an, dec_ddp, exp_an, exp_dec);
        else passed++;
      end
    end
  endtask

  task automatic test_latency();
    set_scan();
    d1 = scan_d(3);
    release_reset();
    @(negedge clock);
    d1 = scan_d(7);
    #1;
    checks++;
    if (dec_ddp !== {seg_of(4'h3), 1'b1})
      $display("FAIL latency_hold dec=%b want %b", dec_ddp, {seg_of(4'h3), 1'b1});
    else passed++;
    @(negedge clock);
    checks++;
    if (dec_ddp !== {seg_of(4'h7), 1'b1} || an !== 8'hFE)
      $display("FAIL latency_update an=%h dec=%b want FE/%b", an, dec_ddp, {seg_of(4'h7), 1'b1});
    else passed++;
  endtask

  task automatic test_guard();
    logic [7:0] exp_an, exp_dec;
    set_scan();
    release_reset();
    for (int k = 0; k < 9 * RD; k++) begin
      @(negedge clock);
      exp_an  = ((k % RD) < GC) ? 8'hFF : an_of((k / RD) % 8);
      exp_dec = {seg_of(4'((k / RD) % 8)), 1'b1};
      checks++;
      if (an !== exp_an || dec_ddp !== exp_dec)
        $display("FAIL guard cyc=%0d an=%h dec=%h want %h/%h", k, an, dec_ddp, exp_an, exp_dec);
      else passed++;
      checks++;
      if ($countones(~an) > 1)
        $display("FAIL guard_onehot cyc=%0d an=%h want at most one low", k, an);
      else passed++;
    end
  endtask

  initial begin
    set_scan();
    test_reset();
`ifdef DSPL_DIGIT_BLANK_GUARD_EN
    test_guard();
`else
    test_scan_order();
    test_decode();
    test_disable();
    test_latency();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
